// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution window generator.
package conv_pkg;

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  localparam int DEF_WORDWIDTH   = 32;
  localparam int DEF_FIG_WIDTH   = 28;
  localparam int DEF_WEIGHTLEN   = 5;
  localparam int DEF_FIG_ADDRLEN = 5;
  localparam int OUT_DIM         = DEF_FIG_WIDTH - DEF_WEIGHTLEN + 1;

  // Output windows per row/column for a given map and kernel size.
  function automatic int out_dim(input int fig_width, input int weightlen);
    return fig_width - weightlen + 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Column-in / window-out stream bundle of the window generator.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int WORDWIDTH   = DEF_WORDWIDTH,
  parameter int WEIGHTLEN   = DEF_WEIGHTLEN,
  parameter int FIG_ADDRLEN = DEF_FIG_ADDRLEN
);

  logic [WORDWIDTH*WEIGHTLEN-1:0]           col_in;
  logic                                     col_valid;
  logic                                     col_ready;
  logic [WORDWIDTH*WEIGHTLEN*WEIGHTLEN-1:0] win_out;
  logic                                     win_valid;
  logic                                     win_ready;
  logic [FIG_ADDRLEN-1:0]                   win_row;
  logic [FIG_ADDRLEN-1:0]                   win_col;
  logic                                     last_win;

  // master = the window generator itself
  modport master (
    input  col_in, col_valid, win_ready,
    output col_ready, win_out, win_valid, win_row, win_col, last_win
  );

  modport slave (
    output col_in, col_valid, win_ready,
    input  col_ready, win_out, win_valid, win_row, win_col, last_win
  );

endinterface

// File: rtl/window_shift_reg.sv
// WEIGHTLEN-deep shift register of pixel columns; exposes the contents
// the register will hold after the current shift so the window can be
// captured on the same edge the column is accepted.
module window_shift_reg #(
  parameter int WORDWIDTH = 32,
  parameter int WEIGHTLEN = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic [WORDWIDTH*WEIGHTLEN-1:0]           col_in,
  output logic [WORDWIDTH*WEIGHTLEN*WEIGHTLEN-1:0] window_next
);

  localparam int COLW = WORDWIDTH * WEIGHTLEN;

  logic [COLW-1:0] col_q [WEIGHTLEN];
  logic [COLW-1:0] col_d [WEIGHTLEN];

  generate
    for (genvar gi = 0; gi < WEIGHTLEN; gi++) begin : g_stage
      // Slot 0 is the oldest (leftmost) column; new data enters at the top slot.
      if (gi == WEIGHTLEN - 1) begin : g_head
        always_comb col_d[gi] = col_in;
      end else begin : g_body
        always_comb col_d[gi] = col_q[gi+1];
      end

      assign window_next[gi*COLW +: COLW] = col_d[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          col_q[gi] <= '0;
        end else if (en) begin
          col_q[gi] <= col_d[gi];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster stream of pixel columns into WEIGHTLEN x WEIGHTLEN windows
// with output coordinates, end-of-frame flag and ready/valid backpressure.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int WORDWIDTH   = DEF_WORDWIDTH,
  parameter int FIG_WIDTH   = DEF_FIG_WIDTH,
  parameter int WEIGHTLEN   = DEF_WEIGHTLEN,
  parameter int FIG_ADDRLEN = DEF_FIG_ADDRLEN
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_gen_if.master bus
);

  localparam int WINW   = WORDWIDTH * WEIGHTLEN * WEIGHTLEN;
  localparam int ODIM   = out_dim(FIG_WIDTH, WEIGHTLEN);

  localparam logic [FIG_ADDRLEN-1:0] LAST_COL  = FIG_ADDRLEN'(FIG_WIDTH - 1);
  localparam logic [FIG_ADDRLEN-1:0] LAST_ROW  = FIG_ADDRLEN'(ODIM - 1);
  localparam logic [FIG_ADDRLEN-1:0] FILL_LAST = FIG_ADDRLEN'(WEIGHTLEN - 2);
  localparam logic [FIG_ADDRLEN-1:0] COL_OFS   = FIG_ADDRLEN'(WEIGHTLEN - 1);

  state_t                 state_q,     state_d;
  logic [FIG_ADDRLEN-1:0] col_cnt_q,   col_cnt_d;
  logic [FIG_ADDRLEN-1:0] row_cnt_q,   row_cnt_d;
  logic [WINW-1:0]        win_out_q,   win_out_d;
  logic                   win_valid_q, win_valid_d;
  logic [FIG_ADDRLEN-1:0] win_row_q,   win_row_d;
  logic [FIG_ADDRLEN-1:0] win_col_q,   win_col_d;
  logic                   last_win_q,  last_win_d;

  logic            accept;
  logic            load;
  logic [WINW-1:0] window_next;

  // An occupied output register blocks input unless it drains this cycle.
  assign bus.col_ready = !win_valid_q || bus.win_ready;
  assign accept        = bus.col_valid && bus.col_ready;

  window_shift_reg #(
    .WORDWIDTH (WORDWIDTH),
    .WEIGHTLEN (WEIGHTLEN)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .en          (accept),
    .col_in      (bus.col_in),
    .window_next (window_next)
  );

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    win_out_d   = win_out_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    last_win_d  = last_win_q;
    load        = 1'b0;

    if (accept) begin
      if (col_cnt_q == LAST_COL) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end

      case (state_q)
        S_FILL: begin
          if (col_cnt_q == FILL_LAST) state_d = S_STREAM;
        end
        S_STREAM: begin
          load = 1'b1;
          if (col_cnt_q == LAST_COL) state_d = S_FILL;
        end
        default: state_d = S_FILL;
      endcase
    end

    // A load wins over a drain so back-to-back windows keep win_valid high.
    if (load) begin
      win_valid_d = 1'b1;
      win_out_d   = window_next;
      win_row_d   = row_cnt_q;
      win_col_d   = col_cnt_q - COL_OFS;
      last_win_d  = (row_cnt_q == LAST_ROW) && (col_cnt_q == LAST_COL);
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      last_win_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      win_out_q   <= win_out_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      last_win_q  <= last_win_d;
    end
  end

  assign bus.win_out   = win_out_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.last_win  = last_win_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: column history model predicts every
// window; a negedge monitor pops and compares on each output handshake.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int WW   = 32;
  localparam int FW   = 28;
  localparam int WL   = 5;
  localparam int AL   = 5;
  localparam int COLW = WW * WL;
  localparam int WINW = WW * WL * WL;
  localparam int FRAME_COLS = FW * OUT_DIM;

  typedef struct {
    logic [WINW-1:0] data;
    int              row;
    int              col;
    bit              last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.WORDWIDTH(WW), .WEIGHTLEN(WL), .FIG_ADDRLEN(AL)) bus ();

  conv_window_gen #(
    .WORDWIDTH   (WW),
    .FIG_WIDTH   (FW),
    .WEIGHTLEN   (WL),
    .FIG_ADDRLEN (AL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   rr_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [COLW-1:0] col_word(input int seq);
    logic [COLW-1:0] w;
    for (int i = 0; i < WL; i++) w[i*WW +: WW] = WW'(seq * 16 + i);
    return w;
  endfunction

  function automatic logic [WW-1:0] win_elem(input logic [WINW-1:0] win, input int k, input int j);
    return win[(k*WL+j)*WW +: WW];
  endfunction

  // Reference model: remembers the last WL accepted columns and raster position.
  int              m_col, m_row;
  logic [COLW-1:0] hist [WL];
  exp_t            m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_col = 0;
      m_row = 0;
      exp_q.delete();
      for (int k = 0; k < WL; k++) hist[k] = '0;
    end else if (bus.col_valid && bus.col_ready) begin
      for (int k = 0; k < WL - 1; k++) hist[k] = hist[k+1];
      hist[WL-1] = bus.col_in;
      if (m_col >= WL - 1) begin
        for (int k = 0; k < WL; k++) m_e.data[k*COLW +: COLW] = hist[k];
        m_e.row  = m_row;
        m_e.col  = m_col - (WL - 1);
        m_e.last = (m_row == OUT_DIM - 1) && (m_col == FW - 1);
        exp_q.push_back(m_e);
      end
      if (m_col == FW - 1) begin
        m_col = 0;
        m_row = (m_row == OUT_DIM - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  end

  // Monitor: handshake compare, stall stability, col_ready relation.
  int              n_win = 0, n_last = 0, win_at_last = -1;
  int              last_row = -1, last_col = -1;
  logic [WINW-1:0] last_data;
  bit              stall_q = 1'b0;
  logic [WINW-1:0] snap_out;
  logic [AL-1:0]   snap_row, snap_col;
  logic            snap_last;
  exp_t            mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      checks++;
      if (bus.col_ready !== (!bus.win_valid || bus.win_ready)) begin
        errors++;
        $display("FAIL col_ready: got %0b with win_valid=%0b win_ready=%0b",
                 bus.col_ready, bus.win_valid, bus.win_ready);
      end
      if (stall_q) begin
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_out !== snap_out || bus.win_row !== snap_row ||
            bus.win_col !== snap_col || bus.last_win !== snap_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b (%0d,%0d) last=%0b, expected held (%0d,%0d) last=%0b",
                   bus.win_valid, bus.win_row, bus.win_col, bus.last_win, snap_row, snap_col, snap_last);
        end
      end
      if (bus.win_valid && bus.win_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got (%0d,%0d), expected none", bus.win_row, bus.win_col);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.win_row !== AL'(mon_e.row) || bus.win_col !== AL'(mon_e.col) ||
              bus.last_win !== mon_e.last) begin
            errors++;
            $display("FAIL win_coord: got (%0d,%0d) last=%0b, expected (%0d,%0d) last=%0b",
                     bus.win_row, bus.win_col, bus.last_win, mon_e.row, mon_e.col, mon_e.last);
          end
          checks++;
          if (bus.win_out !== mon_e.data) begin
            errors++;
            $display("FAIL win_data at (%0d,%0d): got e00=%h e44=%h, expected e00=%h e44=%h",
                     mon_e.row, mon_e.col, win_elem(bus.win_out, 0, 0), win_elem(bus.win_out, 4, 4),
                     win_elem(mon_e.data, 0, 0), win_elem(mon_e.data, 4, 4));
          end
        end
        n_win++;
        if (bus.last_win) begin
          n_last++;
          win_at_last = n_win;
        end
        last_row  = int'(bus.win_row);
        last_col  = int'(bus.win_col);
        last_data = bus.win_out;
        $display("win %0d: (%0d,%0d) last=%0b e00=%h", n_win, bus.win_row, bus.win_col,
                 bus.last_win, win_elem(bus.win_out, 0, 0));
      end
      stall_q   = bus.win_valid && !bus.win_ready;
      snap_out  = bus.win_out;
      snap_row  = bus.win_row;
      snap_col  = bus.win_col;
      snap_last = bus.last_win;
    end
  end

  // Random consumer readiness while enabled.
  always begin
    @(posedge clk);
    #1;
    if (rr_en) bus.win_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_col(input int seq);
    int t = 0;
    bus.col_valid = 1'b1;
    bus.col_in    = col_word(seq);
    @(negedge clk);
    while (!bus.col_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.col_ready) begin
      checks++;
      errors++;
      $display("FAIL col_accept_timeout: column %0d not accepted, expected acceptance within 200 cycles", seq);
    end
    @(posedge clk);
    #1;
    bus.col_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_win_out_zero"}, (bus.win_out == '0) ? 1 : 0, 1);
    chk({tag, "_win_row"}, bus.win_row, 0);
    chk({tag, "_win_col"}, bus.win_col, 0);
    chk({tag, "_last_win"}, bus.last_win, 0);
    chk({tag, "_col_ready"}, bus.col_ready, 1);
  endtask

  logic [WINW-1:0] first_win;
  int              gaps;

  initial begin
    rst           = 1'b1;
    bus.col_valid = 1'b0;
    bus.col_in    = '0;
    bus.win_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Fill: columns 0..3 produce nothing, column 4 gives window (0,0).
    for (int c = 0; c < WL - 1; c++) begin
      send_col(c);
      chk("fill_no_window", bus.win_valid, 0);
    end
    send_col(WL - 1);
    chk("first_valid", bus.win_valid, 1);
    chk("first_row", bus.win_row, 0);
    chk("first_col", bus.win_col, 0);
    for (int k = 0; k < WL; k++)
      for (int j = 0; j < WL; j++) first_win[(k*WL+j)*WW +: WW] = WW'(k * 16 + j);
    chk("first_data", (bus.win_out == first_win) ? 1 : 0, 1);

    // Backpressure: hold window (0,0) for 10 cycles with a column pending.
    bus.win_ready = 1'b0;
    bus.col_valid = 1'b1;
    bus.col_in    = col_word(WL);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_col_ready", bus.col_ready, 0);
      chk("bp_win_col", bus.win_col, 0);
    end
    @(posedge clk);
    #1;
    bus.win_ready = 1'b1;
    send_col(WL);
    chk("bp_next_valid", bus.win_valid, 1);
    chk("bp_next_col", bus.win_col, 1);

    // Rest of the frame with input gaps and random consumer readiness.
    rr_en = 1'b1;
    for (int c = WL + 1; c < FRAME_COLS; c++) begin
      gaps = (c % 3 == 0 ? 1 : 0) + (c % 5 == 0 ? 1 : 0) + (c % 7 == 0 ? 1 : 0);
      idle(gaps);
      send_col(c);
    end
    // First five columns of the next frame.
    for (int c = FRAME_COLS; c < FRAME_COLS + WL; c++) send_col(c);
    rr_en = 1'b0;
    @(posedge clk);
    #1;
    bus.win_ready = 1'b1;
    drain("frame_drain");
    chk("frame_window_count", win_at_last, OUT_DIM * OUT_DIM);
    chk("last_win_count", n_last, 1);
    chk("next_frame_row", last_row, 0);
    chk("next_frame_col", last_col, 0);
    chk("next_frame_e00", win_elem(last_data, 0, 0), FRAME_COLS * 16);

    // Advance second frame to row 3 column 10, then reset mid-cycle.
    for (int c = FRAME_COLS + WL; c < FRAME_COLS + 3 * FW + 10; c++) send_col(c);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    idle(2);
    rst = 1'b0;

    for (int c = 0; c < WL; c++) send_col(1000 + c);
    chk("post_reset_valid", bus.win_valid, 1);
    chk("post_reset_row", bus.win_row, 0);
    chk("post_reset_col", bus.win_col, 0);
    chk("post_reset_e00", win_elem(bus.win_out, 0, 0), 1000 * 16);
    chk("post_reset_e44", win_elem(bus.win_out, 4, 4), 1004 * 16 + 4);
    drain("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
